// File: rtl/vga_sync_gen.sv
// ---------------------------------------------------------------------------
// vga_sync_gen
//   640x480@60 Hz VGA timing generator. Horizontal and vertical region FSMs
//   run alongside raw counters (hcount 0..H_TOTAL-1, vcount 0..V_TOTAL-1).
//   Sync and blank outputs can be delayed by PIPE_DELAY pixel ticks so that
//   they line up with a pipelined colour path.
//
//   Every output is a register, loaded from the next-state values. Each output
//   therefore describes the counter position shown in the same clock cycle.
//
//   Build option:
//     VGA_PIXDIV2_EN  defined   : pix_tick toggles every clk, so the pixel
//                                 rate is clk/2.
//                     undefined : pix_tick is held at 1 after reset.
//
// Ports
//   clk          in   system clock
//   reset        in   asynchronous, active-high reset
//   pix_tick     out  pixel-advance strobe; counters step at the end of a
//                     cycle in which it is 1
//   hcount       out  [9:0] horizontal counter 0..H_TOTAL-1
//   vcount       out  [9:0] vertical counter 0..V_TOTAL-1
//   x_px, y_px   out  [9:0] active-area coordinates, 0 outside the window
//   active       out  visible window flag, not delayed
//   hsync_n      out  horizontal sync, active low, delayed by PIPE_DELAY ticks
//   vsync_n      out  vertical sync, active low, delayed by PIPE_DELAY ticks
//   blank_n      out  0 outside the visible window, delayed by PIPE_DELAY ticks
//   line_start   out  high during the tick cycle that wraps hcount
//                     (H_TOTAL-1 -> 0), so it always coincides with pix_tick=1
//   frame_start  out  high during the tick cycle that wraps both counters
// ---------------------------------------------------------------------------
module vga_sync_gen #(
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int H_ACTIVE   = 640,
    parameter int H_FRONT    = 16,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int V_ACTIVE   = 480,
    parameter int V_FRONT    = 10,
    parameter int PIPE_DELAY = 2
) (
    input  logic       clk,
    input  logic       reset,
    output logic       pix_tick,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic [9:0] x_px,
    output logic [9:0] y_px,
    output logic       active,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       blank_n,
    output logic       line_start,
    output logic       frame_start
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    // A zero-delay build still declares one pipe stage; that stage is unused.
    localparam int PW      = (PIPE_DELAY == 0) ? 1 : PIPE_DELAY;

    localparam logic [9:0] H_SYNC_END  = 10'(H_SYNC - 1);
    localparam logic [9:0] H_BACK_END  = 10'(H_SYNC + H_BACK - 1);
    localparam logic [9:0] H_ACT_START = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] H_ACT_END   = 10'(H_SYNC + H_BACK + H_ACTIVE - 1);
    localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_SYNC_END  = 10'(V_SYNC - 1);
    localparam logic [9:0] V_BACK_END  = 10'(V_SYNC + V_BACK - 1);
    localparam logic [9:0] V_ACT_START = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] V_ACT_END   = 10'(V_SYNC + V_BACK + V_ACTIVE - 1);
    localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);

    typedef enum logic [1:0] {HS = 2'd0, HB = 2'd1, HA = 2'd2, HF = 2'd3} hstate_t;
    typedef enum logic [1:0] {VS = 2'd0, VB = 2'd1, VA = 2'd2, VF = 2'd3} vstate_t;

    // Region lookup from a count. This recovers a state that disagrees with its counter.
    function automatic hstate_t h_region(input logic [9:0] h);
        hstate_t r;
        if (h <= H_SYNC_END) begin
            r = HS;
        end else if (h <= H_BACK_END) begin
            r = HB;
        end else if (h <= H_ACT_END) begin
            r = HA;
        end else begin
            r = HF;
        end
        return r;
    endfunction

    function automatic vstate_t v_region(input logic [9:0] v);
        vstate_t r;
        if (v <= V_SYNC_END) begin
            r = VS;
        end else if (v <= V_BACK_END) begin
            r = VB;
        end else if (v <= V_ACT_END) begin
            r = VA;
        end else begin
            r = VF;
        end
        return r;
    endfunction

    logic          pix_tick_r, pix_tick_s;
    logic [9:0]    hcount_r, hcount_s;
    logic [9:0]    vcount_r, vcount_s;
    hstate_t       hstate_r, hstate_s;
    vstate_t       vstate_r, vstate_s;
    logic [PW-1:0] hpipe_r, hpipe_s;
    logic [PW-1:0] vpipe_r, vpipe_s;
    logic [PW-1:0] bpipe_r, bpipe_s;
    logic [9:0]    x_px_r, x_px_s;
    logic [9:0]    y_px_r, y_px_s;
    logic          active_r, active_s;
    logic          hsync_n_r, hsync_n_s;
    logic          vsync_n_r, vsync_n_s;
    logic          blank_n_r, blank_n_s;
    logic          line_start_r, line_start_s;
    logic          frame_start_r, frame_start_s;
    logic          hsync_raw_s, vsync_raw_s, act_raw_s;

    // Raw sync and window flags of the position currently shown.
    assign hsync_raw_s = (hstate_r == HS);
    assign vsync_raw_s = (vstate_r == VS);
    assign act_raw_s   = (hstate_r == HA) && (vstate_r == VA);

    // Next-state logic: counters, region FSMs, delay lines and derived outputs.
    always_comb begin
`ifdef VGA_PIXDIV2_EN
        pix_tick_s = ~pix_tick_r;
`else
        pix_tick_s = 1'b1;
`endif
        hcount_s = hcount_r;
        vcount_s = vcount_r;
        hstate_s = hstate_r;
        vstate_s = vstate_r;
        hpipe_s  = hpipe_r;
        vpipe_s  = vpipe_r;
        bpipe_s  = bpipe_r;

        if (pix_tick_r) begin
            // The delay line captures the position being left on this tick.
            hpipe_s = PW'({hpipe_r, hsync_raw_s});
            vpipe_s = PW'({vpipe_r, vsync_raw_s});
            bpipe_s = PW'({bpipe_r, act_raw_s});

            if (hcount_r == H_LAST) begin
                hcount_s = 10'd0;
                if (vcount_r == V_LAST) begin
                    vcount_s = 10'd0;
                end else begin
                    vcount_s = vcount_r + 10'd1;
                end
            end else begin
                hcount_s = hcount_r + 10'd1;
            end

            case (hstate_r)
                HS: if (hcount_r == H_SYNC_END) hstate_s = HB; else hstate_s = HS;
                HB: if (hcount_r == H_BACK_END) hstate_s = HA; else hstate_s = HB;
                HA: if (hcount_r == H_ACT_END)  hstate_s = HF; else hstate_s = HA;
                HF: if (hcount_r == H_LAST)     hstate_s = HS; else hstate_s = HF;
                default: hstate_s = h_region(hcount_s);
            endcase

            // The vertical FSM moves only on the tick that ends a line.
            if (hcount_r == H_LAST) begin
                case (vstate_r)
                    VS: if (vcount_r == V_SYNC_END) vstate_s = VB; else vstate_s = VS;
                    VB: if (vcount_r == V_BACK_END) vstate_s = VA; else vstate_s = VB;
                    VA: if (vcount_r == V_ACT_END)  vstate_s = VF; else vstate_s = VA;
                    VF: if (vcount_r == V_LAST)     vstate_s = VS; else vstate_s = VF;
                    default: vstate_s = v_region(vcount_s);
                endcase
            end else begin
                vstate_s = vstate_r;
            end
        end else begin
            hcount_s = hcount_r;
            vcount_s = vcount_r;
        end

        active_s = (hstate_s == HA) && (vstate_s == VA);
        if (active_s) begin
            x_px_s = hcount_s - H_ACT_START;
            y_px_s = vcount_s - V_ACT_START;
        end else begin
            x_px_s = 10'd0;
            y_px_s = 10'd0;
        end

        if (PIPE_DELAY == 0) begin
            hsync_n_s = ~(hstate_s == HS);
            vsync_n_s = ~(vstate_s == VS);
            blank_n_s = active_s;
        end else begin
            hsync_n_s = ~hpipe_s[PW-1];
            vsync_n_s = ~vpipe_s[PW-1];
            blank_n_s = bpipe_s[PW-1];
        end

        // The strobes flag the tick cycle whose closing edge performs the wrap.
        line_start_s  = pix_tick_s && (hcount_s == H_LAST);
        frame_start_s = line_start_s && (vcount_s == V_LAST);
    end

    // State and output registers. Reset clears them asynchronously to "no sync, blanked".
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_tick_r    <= 1'b0;
            hcount_r      <= 10'd0;
            vcount_r      <= 10'd0;
            hstate_r      <= HS;
            vstate_r      <= VS;
            hpipe_r       <= '0;
            vpipe_r       <= '0;
            bpipe_r       <= '0;
            x_px_r        <= 10'd0;
            y_px_r        <= 10'd0;
            active_r      <= 1'b0;
            hsync_n_r     <= 1'b1;
            vsync_n_r     <= 1'b1;
            blank_n_r     <= 1'b0;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            pix_tick_r    <= pix_tick_s;
            hcount_r      <= hcount_s;
            vcount_r      <= vcount_s;
            hstate_r      <= hstate_s;
            vstate_r      <= vstate_s;
            hpipe_r       <= hpipe_s;
            vpipe_r       <= vpipe_s;
            bpipe_r       <= bpipe_s;
            x_px_r        <= x_px_s;
            y_px_r        <= y_px_s;
            active_r      <= active_s;
            hsync_n_r     <= hsync_n_s;
            vsync_n_r     <= vsync_n_s;
            blank_n_r     <= blank_n_s;
            line_start_r  <= line_start_s;
            frame_start_r <= frame_start_s;
        end
    end

    assign pix_tick    = pix_tick_r;
    assign hcount      = hcount_r;
    assign vcount      = vcount_r;
    assign x_px        = x_px_r;
    assign y_px        = y_px_r;
    assign active      = active_r;
    assign hsync_n     = hsync_n_r;
    assign vsync_n     = vsync_n_r;
    assign blank_n     = blank_n_r;
    assign line_start  = line_start_r;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_sync_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_gen
//   Three instances run from one clock and one reset:
//     d0 : standard 640x480 timing, PIPE_DELAY=0
//     d2 : standard 640x480 timing, PIPE_DELAY=2
//     ds : a tiny raster (19x12), PIPE_DELAY=1, so vertical and frame wraps
//          happen often
//   The reference model counts pixel ticks since reset. It derives every
//   expected output from that count with division and modulo.
//   Random run lengths are separated by asynchronous resets.
// ---------------------------------------------------------------------------
module tb_vga_sync_gen;
`ifdef VGA_PIXDIV2_EN
    localparam int K = 2;
`else
    localparam int K = 1;
`endif

    logic clk = 1'b0;
    logic reset;
    logic mon_en = 1'b0;

    logic       pt0, act0, hsn0, vsn0, bln0, ls0, fs0;
    logic [9:0] hc0, vc0, x0, y0;
    logic       pt2, act2, hsn2, vsn2, bln2, ls2, fs2;
    logic [9:0] hc2, vc2, x2, y2;
    logic       pts, acts, hsns, vsns, blns, lss, fss;
    logic [9:0] hcs, vcs, xs, ys;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: ticks completed since reset, the current pix_tick, and
    // whether any clock edge has occurred since reset was released.
    int m_n    = 0;
    bit m_pt   = 1'b0;
    bit m_live = 1'b0;

    // Directed measurement state
    int cyc = 0;
    int last_ls = -1;
    int last_fs = -1;
    int run = 0;
    int f0 = -1;
    bit ls_seen = 1'b0;
    bit run_ok = 1'b0;
    bit prev0 = 1'b1;
    bit prev2 = 1'b1;

    always #5 clk = ~clk;

    vga_sync_gen #(.PIPE_DELAY(0)) u_d0 (
        .clk(clk), .reset(reset), .pix_tick(pt0), .hcount(hc0), .vcount(vc0),
        .x_px(x0), .y_px(y0), .active(act0), .hsync_n(hsn0), .vsync_n(vsn0),
        .blank_n(bln0), .line_start(ls0), .frame_start(fs0));

    vga_sync_gen #(.PIPE_DELAY(2)) u_d2 (
        .clk(clk), .reset(reset), .pix_tick(pt2), .hcount(hc2), .vcount(vc2),
        .x_px(x2), .y_px(y2), .active(act2), .hsync_n(hsn2), .vsync_n(vsn2),
        .blank_n(bln2), .line_start(ls2), .frame_start(fs2));

    vga_sync_gen #(.H_SYNC(4), .H_BACK(3), .H_ACTIVE(10), .H_FRONT(2),
                   .V_SYNC(2), .V_BACK(3), .V_ACTIVE(5), .V_FRONT(2),
                   .PIPE_DELAY(1)) u_ds (
        .clk(clk), .reset(reset), .pix_tick(pts), .hcount(hcs), .vcount(vcs),
        .x_px(xs), .y_px(ys), .active(acts), .hsync_n(hsns), .vsync_n(vsns),
        .blank_n(blns), .line_start(lss), .frame_start(fss));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit in_win(input int p, input int lo, input int n);
        return (p >= lo) && (p < lo + n);
    endfunction

    task automatic check_dut(input string nm,
                             input int hs, input int hb, input int ha, input int hf,
                             input int vs, input int vb, input int va, input int vf,
                             input int d,
                             input logic pt, input logic [9:0] hc, input logic [9:0] vc,
                             input logic [9:0] xp, input logic [9:0] yp, input logic act,
                             input logic hsn, input logic vsn, input logic bln,
                             input logic ls, input logic fs);
        int htot, vtot, h, v, md, hd, vd, ex, ey;
        bit ea, ehs, evs, ebl, els, efs, ept;
        htot = hs + hb + ha + hf;
        vtot = vs + vb + va + vf;
        if (!m_live) begin
            h = 0; v = 0; ea = 1'b0; ehs = 1'b1; evs = 1'b1; ebl = 1'b0;
            els = 1'b0; efs = 1'b0; ept = 1'b0;
        end else begin
            h   = m_n % htot;
            v   = (m_n / htot) % vtot;
            ea  = in_win(h, hs + hb, ha) && in_win(v, vs + vb, va);
            ept = m_pt;
            md  = m_n - d;
            if (md < 0) begin
                ehs = 1'b1; evs = 1'b1; ebl = 1'b0;
            end else begin
                hd  = md % htot;
                vd  = (md / htot) % vtot;
                ehs = !(hd < hs);
                evs = !(vd < vs);
                ebl = in_win(hd, hs + hb, ha) && in_win(vd, vs + vb, va);
            end
            els = m_pt && (h == htot - 1);
            efs = els && (v == vtot - 1);
        end
        ex = ea ? h - (hs + hb) : 0;
        ey = ea ? v - (vs + vb) : 0;
        check({nm, ".pix_tick"},    {31'd0, pt},  {31'd0, ept});
        check({nm, ".hcount"},      {22'd0, hc},  h);
        check({nm, ".vcount"},      {22'd0, vc},  v);
        check({nm, ".x_px"},        {22'd0, xp},  ex);
        check({nm, ".y_px"},        {22'd0, yp},  ey);
        check({nm, ".active"},      {31'd0, act}, {31'd0, ea});
        check({nm, ".hsync_n"},     {31'd0, hsn}, {31'd0, ehs});
        check({nm, ".vsync_n"},     {31'd0, vsn}, {31'd0, evs});
        check({nm, ".blank_n"},     {31'd0, bln}, {31'd0, ebl});
        check({nm, ".line_start"},  {31'd0, ls},  {31'd0, els});
        check({nm, ".frame_start"}, {31'd0, fs},  {31'd0, efs});
    endtask

    task automatic check_all(input string pfx);
        check_dut({pfx, "d0"}, 96, 48, 640, 16, 2, 33, 480, 10, 0,
                  pt0, hc0, vc0, x0, y0, act0, hsn0, vsn0, bln0, ls0, fs0);
        check_dut({pfx, "d2"}, 96, 48, 640, 16, 2, 33, 480, 10, 2,
                  pt2, hc2, vc2, x2, y2, act2, hsn2, vsn2, bln2, ls2, fs2);
        check_dut({pfx, "ds"}, 4, 3, 10, 2, 2, 3, 5, 2, 1,
                  pts, hcs, vcs, xs, ys, acts, hsns, vsns, blns, lss, fss);
    endtask

    // Reference model: it advances the tick count on each clock edge.
    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_n    = 0;
                m_pt   = 1'b0;
                m_live = 1'b0;
            end else begin
                if (m_pt) m_n = m_n + 1;
                m_pt   = (K == 2) ? !m_pt : 1'b1;
                m_live = 1'b1;
            end
        end
    end

    // Monitor: compares against the model on every falling edge, and runs
    // the directed period, width and lag measurements.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                cyc++;
                check_all("");
                if (reset) begin
                    last_ls = -1; last_fs = -1; ls_seen = 1'b0; run_ok = 1'b0;
                    run = 0; f0 = -1; prev0 = 1'b1; prev2 = 1'b1;
                end else begin
                    if (!hsn0 && prev0) begin
                        run    = 0;
                        run_ok = ls_seen;
                        f0     = ls_seen ? cyc : -1;
                    end
                    if (!hsn0) begin
                        run++;
                    end else if (!prev0 && run_ok) begin
                        check("d0.hsync_low_clks", run, 96 * K);
                        run_ok = 1'b0;
                    end
                    if (!hsn2 && prev2 && f0 >= 0) begin
                        check("d2.hsync_lag_clks", cyc - f0, 2 * K);
                        f0 = -1;
                    end
                    if (ls0) begin
                        if (last_ls >= 0) check("d0.line_period_clks", cyc - last_ls, 800 * K);
                        last_ls = cyc;
                        ls_seen = 1'b1;
                    end
                    if (fss) begin
                        if (last_fs >= 0) check("ds.frame_period_clks", cyc - last_fs, 228 * K);
                        last_fs = cyc;
                    end
                    prev0 = hsn0;
                    prev2 = hsn2;
                end
            end
        end
    end

    // Stimulus: random-length runs, each ended by an asynchronous reset
    // placed between clock edges.
    initial begin
        reset = 1'b0;
        #1 reset = 1'b1;
        mon_en = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int s = 0; s < 8; s++) begin
            int ncyc;
            ncyc = $urandom_range(2500, 7000);
            repeat (ncyc) @(negedge clk);
            #2 reset = 1'b1;
            #1 check_all("async_rst.");
            repeat ($urandom_range(1, 3)) @(posedge clk);
            @(negedge clk);
            reset = 1'b0;
        end
        repeat (5000) @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Generates 640x480@60 Hz VGA timing: horizontal/vertical counters, active-low sync pulses, blanking, active-area pixel coordinates and frame/line strobes. Sits upstream of the pixel/colour logic and drives the monitor connector's sync pins. The colour path consumes the raw counters (0..799, 0..524), where the active area starts at h=144, v=35. Optional sync delay aligns hsync/vsync/blank with the colour path's pipeline latency.

## Interface
- H_SYNC, 96, hsync pulse width in pixel ticks
- H_BACK, 48, horizontal back porch
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch
- V_SYNC, 2, vsync pulse width in lines
- V_BACK, 33, vertical back porch
- V_ACTIVE, 480, visible lines
- V_FRONT, 10, vertical front porch
- PIPE_DELAY, 2, pixel ticks of delay on hsync_n/vsync_n/blank_n (0..7)

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pix_tick  out  1  pixel-advance strobe; counters move only when 1
- hcount  out  10  horizontal counter, 0..H_TOTAL-1 (H_TOTAL = 800)
- vcount  out  10  vertical counter, 0..V_TOTAL-1 (V_TOTAL = 525)
- x_px  out  10  active-area column, hcount-144 while active, else 0
- y_px  out  10  active-area row, vcount-35 while active, else 0
- active  out  1  1 when both counters are inside the visible window (undelayed)
- hsync_n  out  1  horizontal sync, active low (delayed PIPE_DELAY)
- vsync_n  out  1  vertical sync, active low (delayed PIPE_DELAY)
- blank_n  out  1  0 outside visible window (delayed PIPE_DELAY)
- line_start  out  1  one-clk pulse when hcount wraps to 0
- frame_start  out  1  one-clk pulse when hcount and vcount both wrap to 0

## Operation
- Horizontal FSM states: HS (hcount 0..95), HB (96..143), HA (144..783), HF (784..799). Transitions are taken on pix_tick at each boundary. HF->HS wraps hcount to 0 and increments vcount.
- Vertical FSM states: VS (0..1), VB (2..34), VA (35..514), VF (515..524). VF->VS wraps vcount to 0 at the end of line 524.
- The state registers and counters must agree at all times. A bench checks state against the count ranges above.
- active = (hstate==HA) && (vstate==VA). x_px/y_px are computed by unsigned 10-bit subtraction, forced to 0 when not active.
- hsync_raw = (hstate==HS), vsync_raw = (vstate==VS). These feed a PIPE_DELAY-deep shift register (advanced on pix_tick) before inversion to hsync_n/vsync_n. blank_n uses the same delay on active.
- PIPE_DELAY=0: hsync_n/vsync_n/blank_n are a direct registered function of the current state.
- line_start and frame_start are asserted for the single clk in which pix_tick causes the wrap. They are never asserted when pix_tick=0.
- All outputs are registered; no combinational path from reset to outputs other than the asynchronous clear.

## Timing
- Reset values: hcount=0, vcount=0, states HS/VS, x_px=0, y_px=0, active=0, hsync_n=1, vsync_n=1, blank_n=0, line_start=0, frame_start=0, pix_tick=0. The delay line is cleared to "no sync, blanked".
- First pix_tick after reset release: hcount 0->1. hsync_n/vsync_n go low PIPE_DELAY ticks after the first tick.
- Line = 800 ticks. Frame = 525 lines = 420000 ticks.
- Reset asserted mid-frame: all outputs take reset values within the same clk (async). The frame restarts from (0,0) with no partial strobe.

## Configuration
- VGA_PIXDIV2_EN defined: pix_tick toggles every clk (1 on alternate cycles, starting 0 after reset). Counters advance at clk/2, e.g. 50 MHz -> 25 MHz pixel rate.
- Undefined: pix_tick is held 1 after reset release, and counters advance every clk.

## Test plan
- Reset, release, macro off, PIPE_DELAY=0 -> hsync_n low for exactly 96 clks, high 704. line_start period 800 clks. frame_start period 420000 clks.
- Full frame -> active high for exactly 307200 clks. First active pixel at hcount=144, vcount=35 with x_px=0, y_px=0. Last active pixel at 783/514 with x_px=639, y_px=479.
- PIPE_DELAY=2 -> hsync_n, vsync_n and blank_n edges lag their PIPE_DELAY=0 positions by exactly 2 clks. active is unchanged.
- VGA_PIXDIV2_EN defined -> pix_tick alternates 0/1, hsync_n low for 192 clks, line period 1600 clks.
- Assert reset at hcount=400, vcount=300 for 3 clks -> outputs show reset values in the assertion clk. After release, the counters restart at 0 and no frame_start occurs until 420000 ticks later.
- vcount wrap at 524->0 -> frame_start and line_start both pulse for one clk, and vsync_n falls (after PIPE_DELAY).
